// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W             = 5;
  localparam int unsigned MC_CYCLES_DEFAULT = 4;

  // Operand source selected by the execute stage.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    EX_EX  = 2'd1,
    MEM_EX = 2'd2
  } fwd_sel_t;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MC_BUSY  = 2'd2
  } hz_state_t;

  // Destination metadata shadowed for the instruction in EX or MEM.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             rd_wren;
    logic             is_load;
  } hz_slot_t;

  // True when a slot with these fields produces register r (x0 never matches).
  function automatic logic slot_writes(input logic             valid,
                                       input logic             wren,
                                       input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] r);
    return valid && wren && (rd == r) && (r != REG_W'(0));
  endfunction

endpackage

// File: rtl/fwd_pick.sv
// Forward-select picker for one source operand: youngest producer wins.
module fwd_pick
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_used,
  input  hz_slot_t         i_ex_slot,
  input  hz_slot_t         i_mem_slot,
  output fwd_sel_t         o_sel_c
);

  // Load flags matter only to load-use detection, not to source selection.
  logic w_unused_load;
  assign w_unused_load = i_ex_slot.is_load ^ i_mem_slot.is_load;

  // EX slot has priority over MEM slot; unused operands never forward.
  always_comb begin
    o_sel_c = NONE;
    if (i_used) begin
      if (slot_writes(i_ex_slot.valid, i_ex_slot.rd_wren, i_ex_slot.rd, i_rs)) begin
        o_sel_c = EX_EX;
      end else if (slot_writes(i_mem_slot.valid, i_mem_slot.rd_wren, i_mem_slot.rd, i_rs)) begin
        o_sel_c = MEM_EX;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: tracks EX/MEM destinations, drives
// operand forwarding selects, load-use and multi-cycle stalls, and flushes.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MC_CYCLES = MC_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_id_rd_wren,
  input  logic             i_id_is_load,
  input  logic             i_id_is_mc,
  input  logic             i_flush,
  output fwd_sel_t         o_fwd_a,
  output fwd_sel_t         o_fwd_b,
  output logic             o_stall,
  output logic             o_bubble_ex,
  output logic             o_mc_busy
);

  localparam int unsigned    CNT_W    = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);

  hz_state_t        r_state;
  hz_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  hz_slot_t         r_ex;
  hz_slot_t         r_mem;
  hz_slot_t         w_id_slot;
  fwd_sel_t         r_fwd_a;
  fwd_sel_t         r_fwd_b;
  fwd_sel_t         w_sel_a;
  fwd_sel_t         w_sel_b;
  logic             w_load_use;
  logic             w_ex_bubble;
  logic             w_shift;

  assign w_id_slot = '{valid:   1'b1,
                       rd:      i_id_rd,
                       rd_wren: i_id_rd_wren,
                       is_load: i_id_is_load};

  // Load in EX produces a register the ID instruction actually reads.
  assign w_load_use = i_id_valid && r_ex.is_load &&
                      ((i_id_rs1_used && slot_writes(r_ex.valid, r_ex.rd_wren, r_ex.rd, i_id_rs1)) ||
                       (i_id_rs2_used && slot_writes(r_ex.valid, r_ex.rd_wren, r_ex.rd, i_id_rs2)));

  // Slots freeze only while a multi-cycle op owns EX.
  assign w_shift     = (r_state != MC_BUSY);
  assign w_ex_bubble = i_flush || o_bubble_ex || !i_id_valid;

  fwd_pick u_pick_a (
    .i_rs       (i_id_rs1),
    .i_used     (i_id_rs1_used),
    .i_ex_slot  (r_ex),
    .i_mem_slot (r_mem),
    .o_sel_c    (w_sel_a)
  );

  fwd_pick u_pick_b (
    .i_rs       (i_id_rs2),
    .i_used     (i_id_rs2_used),
    .i_ex_slot  (r_ex),
    .i_mem_slot (r_mem),
    .o_sel_c    (w_sel_b)
  );

  // FSM state and multi-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and stall/bubble/busy decode; flush beats a load-use stall.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_stall     = 1'b0;
    o_bubble_ex = 1'b0;
    o_mc_busy   = 1'b0;
    case (r_state)
      MC_BUSY: begin
        o_stall   = 1'b1;
        o_mc_busy = 1'b1;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        if (!i_flush) begin
          if (w_load_use) begin
            o_stall     = 1'b1;
            o_bubble_ex = 1'b1;
            w_state_nxt = LU_STALL;
          end else if (i_id_valid && i_id_is_mc) begin
            w_state_nxt = MC_BUSY;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
    endcase
  end

  // Shadow slots and registered forward selects for the instruction entering EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_fwd_a <= NONE;
      r_fwd_b <= NONE;
    end else if (w_shift) begin
      r_mem   <= r_ex;
      r_ex    <= w_ex_bubble ? '0   : w_id_slot;
      r_fwd_a <= w_ex_bubble ? NONE : w_sel_a;
      r_fwd_b <= w_ex_bubble ? NONE : w_sel_b;
    end
  end

  assign o_fwd_a = r_fwd_a;
  assign o_fwd_b = r_fwd_b;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: pipeline-history model plus directed programs.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned MC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_id_valid;
  logic [4:0] i_id_rs1;
  logic [4:0] i_id_rs2;
  logic       i_id_rs1_used;
  logic       i_id_rs2_used;
  logic [4:0] i_id_rd;
  logic       i_id_rd_wren;
  logic       i_id_is_load;
  logic       i_id_is_mc;
  logic       i_flush;
  fwd_sel_t   o_fwd_a;
  fwd_sel_t   o_fwd_b;
  logic       o_stall;
  logic       o_bubble_ex;
  logic       o_mc_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_CYCLES(MC)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_id_valid    (i_id_valid),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_id_rd       (i_id_rd),
    .i_id_rd_wren  (i_id_rd_wren),
    .i_id_is_load  (i_id_is_load),
    .i_id_is_mc    (i_id_is_mc),
    .i_flush       (i_flush),
    .o_fwd_a       (o_fwd_a),
    .o_fwd_b       (o_fwd_b),
    .o_stall       (o_stall),
    .o_bubble_ex   (o_bubble_ex),
    .o_mc_busy     (o_mc_busy)
  );

  // ---------------- reference model ----------------
  // pipe[0] is the instruction in EX, pipe[1] the one in MEM (bubbles included).
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } ent_t;

  ent_t     pipe[$];
  int       busy_left = 0;
  fwd_sel_t m_fa      = NONE;
  fwd_sel_t m_fb      = NONE;
  bit       m_held    = 1'b0;

  function automatic bit writes(ent_t e, int r);
    return e.v && e.wr && (e.rd == r) && (r != 0);
  endfunction

  function automatic fwd_sel_t pick(int r, bit used);
    if (!used) return NONE;
    for (int k = 0; k < 2; k++) begin
      if (k < pipe.size() && writes(pipe[k], r)) return (k == 0) ? EX_EX : MEM_EX;
    end
    return NONE;
  endfunction

  function automatic bit exp_lu();
    if (!i_id_valid || pipe.size() == 0) return 1'b0;
    if (!pipe[0].ld) return 1'b0;
    return (i_id_rs1_used && writes(pipe[0], int'(i_id_rs1))) ||
           (i_id_rs2_used && writes(pipe[0], int'(i_id_rs2)));
  endfunction

  function automatic bit exp_bubble();
    return (busy_left == 0) && exp_lu() && !i_flush;
  endfunction

  function automatic bit exp_stall();
    return (busy_left > 0) || exp_bubble();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe.delete();
      busy_left = 0;
      m_fa      = NONE;
      m_fb      = NONE;
      m_held    = 1'b0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      m_held    = 1'b1;
    end else begin : upd
      bit   lu;
      bit   bub;
      ent_t e;
      lu     = exp_lu() && !i_flush;
      bub    = i_flush || lu || !i_id_valid;
      m_held = lu;
      m_fa   = bub ? NONE : pick(int'(i_id_rs1), i_id_rs1_used);
      m_fb   = bub ? NONE : pick(int'(i_id_rs2), i_id_rs2_used);
      e.v    = !bub;
      e.rd   = bub ? 0 : int'(i_id_rd);
      e.wr   = !bub && i_id_rd_wren;
      e.ld   = !bub && i_id_is_load;
      pipe.push_front(e);
      if (pipe.size() > 2) void'(pipe.pop_back());
      if (!bub && i_id_is_mc) busy_left = int'(MC) - 1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_f(input string name, input fwd_sel_t act, input fwd_sel_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk_b("model_stall",     o_stall,     exp_stall());
    chk_b("model_bubble_ex", o_bubble_ex, exp_bubble());
    chk_b("model_mc_busy",   o_mc_busy,   busy_left > 0);
    chk_f("model_fwd_a",     o_fwd_a,     m_fa);
    chk_f("model_fwd_b",     o_fwd_b,     m_fb);
  end

  // Stimulus never flushes while a multi-cycle op owns EX.
  always @(posedge clk) begin
    if (rst_n && o_mc_busy && i_flush) $error("FAIL flush_in_mc_busy: flush=1 required 0");
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit mc, input bit fl);
    i_id_valid    = v;
    i_id_rs1      = 5'(rs1);
    i_id_rs1_used = u1;
    i_id_rs2      = 5'(rs2);
    i_id_rs2_used = u2;
    i_id_rd       = 5'(rd);
    i_id_rd_wren  = wr;
    i_id_is_load  = ld;
    i_id_is_mc    = mc;
    i_flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clock until the ID instruction has moved into EX, then empty ID.
  task automatic accept();
    int guard;
    guard = 0;
    tick();
    while (m_held && guard < 50) begin
      tick();
      guard++;
    end
    if (m_held) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: still held after %0d cycles, required release", guard);
    end
    idle();
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    drive(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    accept();
  endtask

  task automatic lw(input int rd, input int rs1);
    drive(1'b1, rs1, 1'b1, 0, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
    accept();
  endtask

  task automatic mul(input int rd, input int rs1, input int rs2);
    drive(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b1, 1'b0);
    accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_f("rst_fwd_a", o_fwd_a, NONE);
    chk_f("rst_fwd_b", o_fwd_b, NONE);
    chk_b("rst_stall", o_stall, 1'b0);
    chk_b("rst_mc_busy", o_mc_busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // add x1,x2,x3 ; add x4,x1,x5
    alu(1, 2, 3);
    drive(1'b1, 1, 1'b1, 5, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk_b("b2b_no_stall", o_stall, 1'b0);
    accept();
    chk_f("b2b_fwd_a", o_fwd_a, EX_EX);
    chk_f("b2b_fwd_b", o_fwd_b, NONE);

    // add x1 ; nop ; sub x6,x7,x1
    alu(1, 8, 9);
    alu(0, 0, 0);
    alu(6, 7, 1);
    chk_f("gap_fwd_a", o_fwd_a, NONE);
    chk_f("gap_fwd_b", o_fwd_b, MEM_EX);

    // two older writers of x1: the younger (EX) one wins
    alu(1, 10, 11);
    alu(1, 12, 13);
    alu(6, 1, 1);
    chk_f("prio_fwd_a", o_fwd_a, EX_EX);
    chk_f("prio_fwd_b", o_fwd_b, EX_EX);

    // lw x5,0(x2) ; add x6,x5,x5
    lw(5, 2);
    drive(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk_b("lu_stall", o_stall, 1'b1);
    chk_b("lu_bubble", o_bubble_ex, 1'b1);
    tick();
    chk_b("lu_stall_released", o_stall, 1'b0);
    chk_b("lu_bubble_released", o_bubble_ex, 1'b0);
    chk_f("lu_bubble_fwd_a", o_fwd_a, NONE);
    tick();
    idle();
    chk_f("lu_fwd_a", o_fwd_a, MEM_EX);
    chk_f("lu_fwd_b", o_fwd_b, MEM_EX);

    // x0 never forwards; unused rs2 never forwards
    alu(0, 1, 2);
    alu(7, 0, 0);
    chk_f("x0_fwd_a", o_fwd_a, NONE);
    chk_f("x0_fwd_b", o_fwd_b, NONE);
    drive(1'b1, 9, 1'b1, 7, 1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    accept();
    chk_f("imm_fwd_a", o_fwd_a, NONE);
    chk_f("imm_fwd_b", o_fwd_b, NONE);
    lw(0, 1);
    drive(1'b1, 0, 1'b1, 0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk_b("x0_load_no_stall", o_stall, 1'b0);
    accept();

    // add x1 ; mul x3,x1,x2 ; add x4,x3,x0
    alu(1, 5, 6);
    mul(3, 1, 2);
    chk_f("mul_fwd_a", o_fwd_a, EX_EX);
    drive(1'b1, 3, 1'b1, 0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(MC) - 1; i++) begin
      #1;
      chk_b("mc_stall", o_stall, 1'b1);
      chk_b("mc_busy", o_mc_busy, 1'b1);
      chk_b("mc_no_bubble", o_bubble_ex, 1'b0);
      chk_f("mc_fwd_a_hold", o_fwd_a, EX_EX);
      chk_f("mc_fwd_b_hold", o_fwd_b, NONE);
      tick();
    end
    #1;
    chk_b("mc_stall_released", o_stall, 1'b0);
    chk_b("mc_busy_released", o_mc_busy, 1'b0);
    tick();
    idle();
    chk_f("after_mc_fwd_a", o_fwd_a, EX_EX);
    chk_f("after_mc_fwd_b", o_fwd_b, NONE);

    // load-use cycle overridden by flush
    lw(5, 2);
    drive(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk_b("flush_stall", o_stall, 1'b0);
    chk_b("flush_bubble", o_bubble_ex, 1'b0);
    tick();
    idle();
    chk_f("flush_fwd_a", o_fwd_a, NONE);
    chk_f("flush_fwd_b", o_fwd_b, NONE);
    drive(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk_b("post_flush_stall", o_stall, 1'b0);
    tick();
    idle();
    chk_f("post_flush_fwd_a", o_fwd_a, MEM_EX);
    chk_f("post_flush_fwd_b", o_fwd_b, MEM_EX);

    // reset pulsed during MC_BUSY
    alu(1, 5, 6);
    mul(3, 1, 2);
    tick();
    chk_b("pre_rst_mc_busy", o_mc_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_b("mid_rst_stall", o_stall, 1'b0);
    chk_b("mid_rst_mc_busy", o_mc_busy, 1'b0);
    chk_b("mid_rst_bubble", o_bubble_ex, 1'b0);
    chk_f("mid_rst_fwd_a", o_fwd_a, NONE);
    chk_f("mid_rst_fwd_b", o_fwd_b, NONE);
    tick();
    tick();
    rst_n = 1'b1;
    alu(1, 2, 3);
    chk_f("post_rst_fwd_a", o_fwd_a, NONE);
    chk_b("post_rst_mc_busy", o_mc_busy, 1'b0);
    alu(4, 1, 5);
    chk_f("post_rst_fwd_b2b", o_fwd_a, EX_EX);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
